qam16_tx_sequencer: RTL

Frame-level controller for the QAM16 transmit chain (`top_tx`). It sits between the symbol source and the mapper/pulse-shaping FIR. It paces symbol issue at one symbol per `OSR` clocks, prepends a fixed preamble, and pulls payload symbols through a valid/ready handshake. After the payload it flushes the `TAPS`-tap FIR with zero slots, then signals completion.

---
 rtl/qam16_pkg.sv | 22 ++
 rtl/qam16_tx_sequencer_if.sv | 23 ++
 rtl/qam16_slot_timer.sv | 32 +++
 rtl/qam16_tx_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/qam16_pkg.sv
// Shared types and constants for the QAM16 transmit-chain sequencer.
// Holds the frame state enum, symbol width, preamble symbols and the flush-slot helper.
package qam16_pkg;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_PREAMBLE = 2'd1,
      S_PAYLOAD  = 2'd2,
      S_FLUSH    = 2'd3
   } tx_seq_state_t;

   localparam int QAM16_SYM_W = 4;

   localparam logic [QAM16_SYM_W-1:0] PRE_SYM_A = 4'h0;
   localparam logic [QAM16_SYM_W-1:0] PRE_SYM_B = 4'hF;

   // Zero slots needed to push the last real symbol through a TAPS-long FIR at OSR samples per slot.
   function automatic int flush_slots(input int taps, input int osr);
      return (taps + osr - 1) / osr;
   endfunction

endpackage

// File: rtl/qam16_tx_sequencer_if.sv
// Symbol-stream bundle: payload source handshake in, paced symbol slots out to the mapper.
// Handshake: a payload symbol moves on a cycle where din_valid and din_ready are both high; din_ready is never conditioned on din_valid.
interface qam16_tx_sequencer_if;
   import qam16_pkg::*;

   logic [QAM16_SYM_W-1:0] din;
   logic                   din_valid;
   logic                   din_ready;
   logic [QAM16_SYM_W-1:0] sym_out;
   logic                   sym_strobe;
   logic                   sym_zero;

   modport master (
      input  din, din_valid,
      output din_ready, sym_out, sym_strobe, sym_zero
   );

   modport slave (
      output din, din_valid,
      input  din_ready, sym_out, sym_strobe, sym_zero
   );

endinterface

// File: rtl/qam16_slot_timer.sv
// Slot phase counter: counts 0..OSR-1 while enabled and flags the last and next-to-last phase.
// A clear loads CLEAR_PHASE so the owner can choose where the first slot boundary lands.
module qam16_slot_timer #(
   parameter int OSR         = 4,
   parameter int CLEAR_PHASE = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_en,
   output logic o_wrap,
   output logic o_pre_wrap
);

   localparam int PH_W = (OSR > 2) ? $clog2(OSR) : 1;

   logic [PH_W-1:0] r_phase;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_phase <= '0;
      end else if (i_clear) begin
         r_phase <= PH_W'(CLEAR_PHASE);
      end else if (i_en) begin
         r_phase <= o_wrap ? '0 : r_phase + PH_W'(1);
      end
   end

   assign o_wrap     = i_en && (r_phase == PH_W'(OSR - 1));
   assign o_pre_wrap = i_en && (r_phase == PH_W'(OSR - 2));

endmodule

// File: rtl/qam16_tx_sequencer.sv
// Frame controller for the QAM16 transmitter: paces slots, sends preamble, pulls payload, flushes the FIR.
// Define QAM16_TX_SEQ_PREAMBLE_EN to include the preamble phase; otherwise a frame opens straight into payload.
module qam16_tx_sequencer
   import qam16_pkg::*;
#(
   parameter int OSR          = 4,
   parameter int TAPS         = 11,
   parameter int PREAMBLE_LEN = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        i_start,
   input  logic [7:0]                  i_frame_len,
   qam16_tx_sequencer_if.master        sym_if,
   output logic                        o_fir_en,
   output logic                        o_busy,
   output logic                        o_done,
   output logic                        o_underrun,
   output tx_seq_state_t               o_state
);

   localparam int F    = flush_slots(TAPS, OSR);
   localparam int FL_W = (F > 1) ? $clog2(F) : 1;

`ifdef QAM16_TX_SEQ_PREAMBLE_EN
   localparam int PRE_W       = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
   localparam int START_PHASE = 0;
   logic [PRE_W-1:0] r_pre_cnt;
`else
   // No preamble: the start cycle is treated as the last phase of a virtual slot, so it doubles as the first ready cycle.
   localparam int START_PHASE = OSR - 1;
`endif

   tx_seq_state_t          r_state;
   logic [7:0]             r_len;
   logic [7:0]             r_pay_cnt;
   logic [FL_W-1:0]        r_flush_cnt;
   logic                   r_din_ready;
   logic [QAM16_SYM_W-1:0] r_sym_out;
   logic                   r_sym_strobe;
   logic                   r_sym_zero;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_underrun;

   logic w_start;
   logic w_wrap;
   logic w_pre_wrap;
   logic w_pre_last;
   logic w_slot_end;

   assign w_start = (r_state == S_IDLE) && i_start;

`ifdef QAM16_TX_SEQ_PREAMBLE_EN
   assign w_pre_last = (r_pre_cnt == PRE_W'(PREAMBLE_LEN - 1));
`else
   assign w_pre_last = 1'b0;
`endif

   // Wraps that launch either a payload slot or the first flush slot.
   assign w_slot_end = w_wrap && ((r_state == S_PAYLOAD) || ((r_state == S_PREAMBLE) && w_pre_last));

   qam16_slot_timer #(
      .OSR         (OSR),
      .CLEAR_PHASE (START_PHASE)
   ) u_slot_timer (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (w_start),
      .i_en       (r_busy),
      .o_wrap     (w_wrap),
      .o_pre_wrap (w_pre_wrap)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_len        <= '0;
         r_pay_cnt    <= '0;
         r_flush_cnt  <= '0;
         r_din_ready  <= 1'b0;
         r_sym_out    <= '0;
         r_sym_strobe <= 1'b0;
         r_sym_zero   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_underrun   <= 1'b0;
`ifdef QAM16_TX_SEQ_PREAMBLE_EN
         r_pre_cnt    <= '0;
`endif
      end else begin
         r_sym_strobe <= 1'b0;
         r_sym_zero   <= 1'b0;
         r_done       <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_len       <= i_frame_len;
                  r_underrun  <= 1'b0;
                  r_pay_cnt   <= '0;
                  r_flush_cnt <= '0;
                  r_busy      <= 1'b1;
`ifdef QAM16_TX_SEQ_PREAMBLE_EN
                  r_state      <= S_PREAMBLE;
                  r_pre_cnt    <= '0;
                  r_sym_out    <= PRE_SYM_A;
                  r_sym_strobe <= 1'b1;
`else
                  r_state      <= S_PAYLOAD;
                  r_din_ready  <= (i_frame_len != 8'd0);
`endif
               end
            end
`ifdef QAM16_TX_SEQ_PREAMBLE_EN
            S_PREAMBLE: begin
               if (w_pre_wrap) r_din_ready <= w_pre_last && (r_len != 8'd0);
               if (w_wrap && !w_pre_last) begin
                  r_pre_cnt    <= r_pre_cnt + PRE_W'(1);
                  r_sym_out    <= r_pre_cnt[0] ? PRE_SYM_A : PRE_SYM_B;
                  r_sym_strobe <= 1'b1;
               end
            end
`endif
            S_PAYLOAD: begin
               if (w_pre_wrap) r_din_ready <= (r_pay_cnt < r_len);
            end
            S_FLUSH: begin
               if (w_wrap) begin
                  if (r_flush_cnt == FL_W'(F - 1)) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_flush_cnt  <= r_flush_cnt + FL_W'(1);
                     r_sym_strobe <= 1'b1;
                     r_sym_zero   <= 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // A ready cycle with no data still spends the slot, but as an uncounted zero slot.
         if (w_slot_end) begin
            r_din_ready  <= 1'b0;
            r_sym_strobe <= 1'b1;
            if (!r_din_ready) begin
               r_state    <= S_FLUSH;
               r_sym_out  <= '0;
               r_sym_zero <= 1'b1;
            end else if (sym_if.din_valid) begin
               r_state   <= S_PAYLOAD;
               r_sym_out <= sym_if.din;
               r_pay_cnt <= r_pay_cnt + 8'd1;
            end else begin
               r_state    <= S_PAYLOAD;
               r_sym_out  <= '0;
               r_sym_zero <= 1'b1;
               r_underrun <= 1'b1;
            end
         end
      end
   end

   assign sym_if.din_ready  = r_din_ready;
   assign sym_if.sym_out    = r_sym_out;
   assign sym_if.sym_strobe = r_sym_strobe;
   assign sym_if.sym_zero   = r_sym_zero;
   assign o_fir_en          = r_busy;
   assign o_busy            = r_busy;
   assign o_done            = r_done;
   assign o_underrun        = r_underrun;
   assign o_state           = r_state;

endmodule
